// File: rtl/write_back_pkg.sv
// Shared pipeline definitions: opcode values and instruction field positions.
// Every stage decodes instructions through these constants.
package write_back_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_AND = 6'h03;
  localparam logic [5:0] OP_OR  = 6'h04;
  localparam logic [5:0] OP_XOR = 6'h05;
  localparam logic [5:0] OP_SLT = 6'h06;
  localparam logic [5:0] OP_LW  = 6'h08;
  localparam logic [5:0] OP_SW  = 6'h09;
  localparam logic [5:0] OP_BR  = 6'h0A;
  localparam logic [5:0] OP_J   = 6'h0B;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  // ALU class is a contiguous opcode range ADD..SLT.
  function automatic logic is_alu_op(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_SLT);
  endfunction

endpackage

// File: rtl/write_back_decode.sv
// Combinational write-back decode: classifies the instruction and selects
// the destination field (rd for ALU ops, rt for loads).
module wb_decode
  import write_back_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [DATA_W-1:0] ir,
  output logic              is_alu,
  output logic              is_load,
  output logic [REG_AW-1:0] dest
);

  logic [5:0] op;
  logic       unused_fields;

  assign op      = ir[OP_HI:OP_LO];
  assign is_alu  = is_alu_op(op);
  assign is_load = (op == OP_LW);
  assign dest    = is_load ? REG_AW'(ir[RT_HI:RT_LO]) : REG_AW'(ir[RD_HI:RD_LO]);

  // rs and the immediate/function bits play no part in write-back.
  assign unused_fields = ^{ir[RS_HI:RS_LO], ir[RD_LO-1:0]};

endmodule

// File: rtl/write_back.sv
// Write-back stage: registers result data, destination and write enable one
// clock after the instruction is presented. Writes to register 0 are squashed.
module write_back
  import write_back_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] MEM_WB_LMD,
  input  logic [DATA_W-1:0] EX_MEM_IR,
  input  logic [DATA_W-1:0] EX_MEM_ALU_output,
  output logic [DATA_W-1:0] MEM_WB_D,
  output logic              MEM_WB_we,
  output logic [REG_AW-1:0] MEM_WB_rd
);

  logic              is_alu;
  logic              is_load;
  logic [REG_AW-1:0] dest;

  wb_decode #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_decode (
    .ir      (EX_MEM_IR),
    .is_alu  (is_alu),
    .is_load (is_load),
    .dest    (dest)
  );

  // Non-writing instructions leave D and rd untouched; only we drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_WB_D  <= '0;
      MEM_WB_we <= 1'b0;
      MEM_WB_rd <= '0;
    end else if (is_alu || is_load) begin
      MEM_WB_D  <= is_load ? MEM_WB_LMD : EX_MEM_ALU_output;
      MEM_WB_rd <= dest;
      MEM_WB_we <= (dest != '0);
    end else begin
      MEM_WB_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Directed self-checking bench for write_back; each task checks
// {D, we, rd} against hand-computed values one clock after stimulus.
module tb_write_back;

  logic        clk;
  logic        rst;
  logic [31:0] lmd;
  logic [31:0] ir;
  logic [31:0] alu;
  logic [31:0] d;
  logic        we;
  logic [4:0]  rd;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [37:0] exp_v;
  logic [37:0] act_v;

  write_back #(.DATA_W(32), .REG_AW(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .MEM_WB_LMD        (lmd),
    .EX_MEM_IR         (ir),
    .EX_MEM_ALU_output (alu),
    .MEM_WB_D          (d),
    .MEM_WB_we         (we),
    .MEM_WB_rd         (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ir = 32'h04221800; alu = 32'd456; lmd = 32'd123;
    step();
    step();
    exp_v = {32'd0, 1'b0, 5'd0}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL reset: got D=%0d we=%0b rd=%0d, want D=0 we=0 rd=0", d, we, rd);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    for (int op = 1; op <= 6; op++) begin
      ir  = {6'(op), 26'h0221800};
      alu = (op == 1) ? 32'd456 : 32'd456 + 32'(op) * 32'd1000;
      lmd = 32'd123;
      step();
      exp_v = {alu, 1'b1, 5'd3}; act_v = {d, we, rd};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL alu_op%0d: got D=%0d we=%0b rd=%0d, want D=%0d we=1 rd=3",
                 op, d, we, rd, alu);
      end
    end
  endtask

  task automatic test_load();
    ir = 32'h20850004; lmd = 32'd123; alu = 32'd456;
    step();
    exp_v = {32'd123, 1'b1, 5'd5}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL load: got D=%0d we=%0b rd=%0d, want D=123 we=1 rd=5", d, we, rd);
    end
  endtask

  task automatic test_no_write();
    logic [31:0] irs [6];
    irs[0] = 32'h24850008; irs[1] = 32'h28850000; irs[2] = 32'h2C000000;
    irs[3] = 32'h00001800; irs[4] = 32'h1C221800; irs[5] = 32'hFC221800;
    for (int i = 0; i < 6; i++) begin
      ir = irs[i]; alu = 32'd900 + 32'(i); lmd = 32'd700 + 32'(i);
      step();
      exp_v = {32'd123, 1'b0, 5'd5}; act_v = {d, we, rd};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL no_write_%0d (ir=%h): got D=%0d we=%0b rd=%0d, want D=123 we=0 rd=5",
                 i, ir, d, we, rd);
      end
    end
  endtask

  task automatic test_r0_guard();
    ir = {6'h01, 5'd1, 5'd2, 5'd0, 11'd0}; alu = 32'd7; lmd = 32'd99;
    step();
    exp_v = {32'd7, 1'b0, 5'd0}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL r0_alu: got D=%0d we=%0b rd=%0d, want D=7 we=0 rd=0", d, we, rd);
    end
    ir = {6'h08, 5'd1, 5'd0, 16'd4}; alu = 32'd8; lmd = 32'd55;
    step();
    exp_v = {32'd55, 1'b0, 5'd0}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL r0_load: got D=%0d we=%0b rd=%0d, want D=55 we=0 rd=0", d, we, rd);
    end
  endtask

  task automatic test_timing();
    ir = 32'h04221800; alu = 32'd10; lmd = 32'd1;
    step();
    #1 alu = 32'd20;
    #2;
    exp_v = {32'd10, 1'b1, 5'd3}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL timing_hold: got D=%0d we=%0b rd=%0d, want D=10 we=1 rd=3", d, we, rd);
    end
    #2 alu = 32'd30;
    step();
    exp_v = {32'd30, 1'b1, 5'd3}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL timing_edge: got D=%0d we=%0b rd=%0d, want D=30 we=1 rd=3", d, we, rd);
    end
  endtask

  task automatic test_reset_mid();
    ir = {6'h03, 5'd0, 5'd0, 5'd4, 11'd0}; alu = 32'd11;
    step();
    exp_v = {32'd11, 1'b1, 5'd4}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL mid_pre: got D=%0d we=%0b rd=%0d, want D=11 we=1 rd=4", d, we, rd);
    end
    rst = 1'b1; ir = {6'h01, 5'd0, 5'd0, 5'd9, 11'd0}; alu = 32'd22;
    step();
    exp_v = {32'd0, 1'b0, 5'd0}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL mid_rst: got D=%0d we=%0b rd=%0d, want D=0 we=0 rd=0", d, we, rd);
    end
    rst = 1'b0; ir = {6'h08, 5'd2, 5'd6, 16'd0}; lmd = 32'd33;
    step();
    exp_v = {32'd33, 1'b1, 5'd6}; act_v = {d, we, rd};
    tests_run++;
    if (act_v !== exp_v) begin
      tests_failed++;
      $display("FAIL mid_post: got D=%0d we=%0b rd=%0d, want D=33 we=1 rd=6", d, we, rd);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        ir = {6'h05, 5'd0, 5'd0, 5'(10 + i), 11'd0}; alu = 32'hA000 + 32'(i); lmd = 32'hB000;
        exp_v = {32'hA000 + 32'(i), 1'b1, 5'(10 + i)};
      end else begin
        ir = {6'h08, 5'd0, 5'(20 + i), 16'd0}; alu = 32'hC000; lmd = 32'hD000 + 32'(i);
        exp_v = {32'hD000 + 32'(i), 1'b1, 5'(20 + i)};
      end
      step();
      act_v = {d, we, rd};
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got {D,we,rd}=%h, want %h", i, act_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ir = '0; alu = '0; lmd = '0;
    test_reset();
    test_alu();
    test_load();
    test_no_write();
    test_r0_guard();
    test_timing();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
